// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared branch predictor constants, counter type and counter update helper
package bpu_pkg;

  localparam int DEFAULT_INDEX_W = 4;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } ctr_e;

  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    if (taken) begin
      if (c != CTR_ST) n = ctr_e'(c + 2'd1);
    end else begin
      if (c != CTR_SNT) n = ctr_e'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/br_resolve.sv
// rtl/br_resolve.sv - funct3 and comparator flags to branch outcome decode
module br_resolve
  import bpu_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_br_less,
  input  logic       i_br_equal,
  output logic       o_taken,
  output logic       o_legal,
  output logic       o_br_un
);

  assign o_br_un = i_funct3[1];

  always_comb begin
    o_taken = 1'b0;
    o_legal = 1'b1;
    case (i_funct3)
      F3_BEQ:          o_taken = i_br_equal;
      F3_BNE:          o_taken = !i_br_equal;
      F3_BLT, F3_BLTU: o_taken = i_br_less;
      F3_BGE, F3_BGEU: o_taken = !i_br_less;
      default:         o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped branch target buffer with 2-bit counters
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int INDEX_W = DEFAULT_INDEX_W
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_br,
  input  logic [2:0]  i_ex_funct3,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  output logic        o_br_un,
  output logic        o_ex_taken,
  output logic        o_flush,
  output logic [31:0] o_redirect_pc
);

  localparam int DEPTH = 2 ** INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  logic             valid_q  [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];
  ctr_e             ctr_q    [DEPTH];
  logic             flush_q;
  logic [31:0]      redirect_q;

  logic [INDEX_W-1:0] f_idx, ex_idx;
  logic [TAG_W-1:0]   f_tag, ex_tag;
  logic               f_hit, ex_hit;
  logic               raw_taken, legal, resolved, taken, mispredict, wr_en;
  ctr_e               wr_ctr_d;
  logic [31:0]        wr_target_d, redirect_d;
  logic               unused_pc_lsb;

  assign unused_pc_lsb = ^i_pc[1:0];

  assign f_idx  = i_pc[INDEX_W+1:2];
  assign f_tag  = i_pc[31:INDEX_W+2];
  assign ex_idx = i_ex_pc[INDEX_W+1:2];
  assign ex_tag = i_ex_pc[31:INDEX_W+2];

  // Reads see only registered state, so a same-cycle update is visible next cycle.
  assign f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign o_pred_taken  = f_hit && (ctr_q[f_idx] inside {CTR_WT, CTR_ST});
  assign o_pred_target = o_pred_taken ? target_q[f_idx] : 32'd0;

  br_resolve u_br_resolve (
    .i_funct3   (i_ex_funct3),
    .i_br_less  (i_br_less),
    .i_br_equal (i_br_equal),
    .o_taken    (raw_taken),
    .o_legal    (legal),
    .o_br_un    (o_br_un)
  );

  assign resolved   = i_ex_valid && i_ex_is_br && legal;
  assign taken      = resolved && raw_taken;
  assign o_ex_taken = taken;
  assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign mispredict = resolved && ((taken != i_ex_pred_taken) ||
                                   (taken && (i_ex_pred_target != i_ex_target)));
  // Not-taken misses never allocate.
  assign wr_en      = resolved && (ex_hit || taken);

  always_comb begin
    wr_ctr_d    = ex_hit ? ctr_next(ctr_q[ex_idx], taken) : CTR_WT;
    wr_target_d = taken ? i_ex_target : target_q[ex_idx];
    redirect_d  = redirect_q;
    if (mispredict) redirect_d = taken ? i_ex_target : (i_ex_pc + 32'd4);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      flush_q    <= mispredict;
      redirect_q <= redirect_d;
      if (wr_en) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= wr_target_d;
        ctr_q[ex_idx]    <= wr_ctr_d;
      end
    end
  end

  assign o_flush       = flush_q;
  assign o_redirect_pc = redirect_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - scoreboard bench for branch_predict_unit
module tb_branch_predict_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_pc = '0;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        i_ex_valid = 1'b0;
  logic        i_ex_is_br = 1'b0;
  logic [2:0]  i_ex_funct3 = '0;
  logic [31:0] i_ex_pc = '0;
  logic [31:0] i_ex_target = '0;
  logic        i_ex_pred_taken = 1'b0;
  logic [31:0] i_ex_pred_target = '0;
  logic        i_br_less = 1'b0;
  logic        i_br_equal = 1'b0;
  logic        o_br_un;
  logic        o_ex_taken;
  logic        o_flush;
  logic [31:0] o_redirect_pc;

  always #5 i_clk = ~i_clk;

  branch_predict_unit #(.INDEX_W(4)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_pc             (i_pc),
    .o_pred_taken     (o_pred_taken),
    .o_pred_target    (o_pred_target),
    .i_ex_valid       (i_ex_valid),
    .i_ex_is_br       (i_ex_is_br),
    .i_ex_funct3      (i_ex_funct3),
    .i_ex_pc          (i_ex_pc),
    .i_ex_target      (i_ex_target),
    .i_ex_pred_taken  (i_ex_pred_taken),
    .i_ex_pred_target (i_ex_pred_target),
    .i_br_less        (i_br_less),
    .i_br_equal       (i_br_equal),
    .o_br_un          (o_br_un),
    .o_ex_taken       (o_ex_taken),
    .o_flush          (o_flush),
    .o_redirect_pc    (o_redirect_pc)
  );

  typedef struct packed {
    logic        flush;
    logic [31:0] redir;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] last_redir = '0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic resolve(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic eq, input logic lt, input logic pt, input logic [31:0] ptgt);
    logic legal, tk, mis;
    exp_t x;
    i_ex_valid = 1'b1; i_ex_is_br = 1'b1; i_ex_funct3 = f3; i_ex_pc = pc; i_ex_target = tgt;
    i_br_equal = eq; i_br_less = lt; i_ex_pred_taken = pt; i_ex_pred_target = ptgt;
    legal = 1'b1;
    tk = 1'b0;
    case (f3)
      3'b000: tk = eq;
      3'b001: tk = !eq;
      3'b100, 3'b110: tk = lt;
      3'b101, 3'b111: tk = !lt;
      default: legal = 1'b0;
    endcase
    mis = legal && ((tk != pt) || (tk && ptgt != tgt));
    if (mis) last_redir = tk ? tgt : pc + 32'd4;
    x.flush = mis;
    x.redir = last_redir;
    sb.push_back(x);
  endtask

  task automatic idle();
    exp_t x;
    i_ex_valid = 1'b0; i_ex_is_br = 1'b0;
    x.flush = 1'b0;
    x.redir = last_redir;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{flush: 1'b0, redir: last_redir};
  endtask

  task automatic test_reset();
    #12;
    i_pc = 32'h100;
    #1;
    n_tests++;
    if (o_pred_taken !== 1'b0 || o_pred_target !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_pred: taken=%0b target=%h, expected 0/0", o_pred_taken, o_pred_target);
    end
    n_tests++;
    if (o_flush !== 1'b0 || o_redirect_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_flush: flush=%0b redirect=%h, expected 0/0", o_flush, o_redirect_pc);
    end
    i_rst_n = 1'b1;
    idle(); tick();
    n_tests++;
    if (o_flush !== e.flush || o_redirect_pc !== e.redir) begin
      n_fail++;
      $display("FAIL reset_idle: flush=%0b redirect=%h, expected %0b/%h", o_flush, o_redirect_pc, e.flush, e.redir);
    end
  endtask

  task automatic test_alloc();
    resolve(3'b000, 32'h100, 32'h80, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    n_tests++;
    if (o_ex_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL alloc_ex_taken: got %0b, expected 1", o_ex_taken);
    end
    tick();
    n_tests++;
    if (o_flush !== e.flush || o_redirect_pc !== e.redir) begin
      n_fail++;
      $display("FAIL alloc_flush: flush=%0b redirect=%h, expected %0b/%h", o_flush, o_redirect_pc, e.flush, e.redir);
    end
    i_pc = 32'h100;
    #1;
    n_tests++;
    if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h80) begin
      n_fail++;
      $display("FAIL alloc_pred: taken=%0b target=%h, expected 1/00000080", o_pred_taken, o_pred_target);
    end
  endtask

  task automatic test_counter();
    for (int i = 0; i < 2; i++) begin
      resolve(3'b000, 32'h100, 32'h80, 1'b0, 1'b0, 1'b1, 32'h80);
      tick();
      n_tests++;
      if (o_flush !== e.flush || o_redirect_pc !== e.redir) begin
        n_fail++;
        $display("FAIL ctr_down_%0d: flush=%0b redirect=%h, expected %0b/%h", i, o_flush, o_redirect_pc, e.flush, e.redir);
      end
    end
    i_pc = 32'h100;
    #1;
    n_tests++;
    if (o_pred_taken !== 1'b0 || o_pred_target !== 32'h0) begin
      n_fail++;
      $display("FAIL ctr_snt_pred: taken=%0b target=%h, expected 0/0", o_pred_taken, o_pred_target);
    end
    for (int i = 0; i < 4; i++) begin
      resolve(3'b000, 32'h100, 32'h80, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      n_tests++;
      if (o_flush !== e.flush || o_redirect_pc !== e.redir) begin
        n_fail++;
        $display("FAIL ctr_up_%0d: flush=%0b redirect=%h, expected %0b/%h", i, o_flush, o_redirect_pc, e.flush, e.redir);
      end
    end
    n_tests++;
    if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h80) begin
      n_fail++;
      $display("FAIL ctr_st_pred: taken=%0b target=%h, expected 1/00000080", o_pred_taken, o_pred_target);
    end
    resolve(3'b000, 32'h100, 32'h80, 1'b0, 1'b0, 1'b1, 32'h80);
    tick();
    n_tests++;
    if (o_pred_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL ctr_sat_wt: taken=%0b, expected 1", o_pred_taken);
    end
    resolve(3'b000, 32'h100, 32'h80, 1'b0, 1'b0, 1'b1, 32'h80);
    tick();
    n_tests++;
    if (o_pred_taken !== 1'b0 || o_flush !== e.flush || o_redirect_pc !== e.redir) begin
      n_fail++;
      $display("FAIL ctr_sat_wnt: taken=%0b flush=%0b redirect=%h, expected 0/%0b/%h", o_pred_taken, o_flush, o_redirect_pc, e.flush, e.redir);
    end
  endtask

  task automatic test_unsigned();
    resolve(3'b110, 32'h208, 32'h300, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    n_tests++;
    if (o_br_un !== 1'b1 || o_ex_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL bltu_decode: br_un=%0b taken=%0b, expected 1/1", o_br_un, o_ex_taken);
    end
    tick();
    n_tests++;
    if (o_flush !== e.flush || o_redirect_pc !== e.redir) begin
      n_fail++;
      $display("FAIL bltu_flush: flush=%0b redirect=%h, expected %0b/%h", o_flush, o_redirect_pc, e.flush, e.redir);
    end
    resolve(3'b100, 32'h20C, 32'h400, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    n_tests++;
    if (o_br_un !== 1'b0 || o_ex_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL blt_decode: br_un=%0b taken=%0b, expected 0/0", o_br_un, o_ex_taken);
    end
    tick();
    n_tests++;
    if (o_flush !== e.flush || o_redirect_pc !== e.redir) begin
      n_fail++;
      $display("FAIL blt_hold: flush=%0b redirect=%h, expected %0b/%h", o_flush, o_redirect_pc, e.flush, e.redir);
    end
  endtask

  task automatic test_alias();
    resolve(3'b000, 32'h140, 32'h500, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    n_tests++;
    if (o_flush !== e.flush || o_redirect_pc !== e.redir) begin
      n_fail++;
      $display("FAIL alias_flush: flush=%0b redirect=%h, expected %0b/%h", o_flush, o_redirect_pc, e.flush, e.redir);
    end
    i_pc = 32'h100;
    #1;
    n_tests++;
    if (o_pred_taken !== 1'b0 || o_pred_target !== 32'h0) begin
      n_fail++;
      $display("FAIL alias_old_miss: taken=%0b target=%h, expected 0/0", o_pred_taken, o_pred_target);
    end
    i_pc = 32'h140;
    resolve(3'b000, 32'h140, 32'h600, 1'b1, 1'b0, 1'b1, 32'h500);
    #1;
    n_tests++;
    if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h500) begin
      n_fail++;
      $display("FAIL alias_pre_update: taken=%0b target=%h, expected 1/00000500", o_pred_taken, o_pred_target);
    end
    tick();
    n_tests++;
    if (o_flush !== e.flush || o_redirect_pc !== e.redir || o_pred_target !== 32'h600) begin
      n_fail++;
      $display("FAIL alias_post_update: flush=%0b redirect=%h target=%h, expected %0b/%h/00000600", o_flush, o_redirect_pc, o_pred_target, e.flush, e.redir);
    end
  endtask

  task automatic test_back_to_back();
    resolve(3'b000, 32'hFFFF_FFFC, 32'h10, 1'b0, 1'b0, 1'b1, 32'h10);
    tick();
    n_tests++;
    if (o_flush !== e.flush || o_redirect_pc !== e.redir) begin
      n_fail++;
      $display("FAIL b2b_wrap: flush=%0b redirect=%h, expected %0b/%h", o_flush, o_redirect_pc, e.flush, e.redir);
    end
    resolve(3'b001, 32'h300, 32'h900, 1'b1, 1'b0, 1'b1, 32'h900);
    tick();
    n_tests++;
    if (o_flush !== e.flush || o_redirect_pc !== e.redir) begin
      n_fail++;
      $display("FAIL b2b_bne: flush=%0b redirect=%h, expected %0b/%h", o_flush, o_redirect_pc, e.flush, e.redir);
    end
    resolve(3'b101, 32'h404, 32'h1000, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    n_tests++;
    if (o_flush !== e.flush || o_redirect_pc !== e.redir) begin
      n_fail++;
      $display("FAIL b2b_bge: flush=%0b redirect=%h, expected %0b/%h", o_flush, o_redirect_pc, e.flush, e.redir);
    end
    idle();
    tick();
    n_tests++;
    if (o_flush !== e.flush || o_redirect_pc !== e.redir) begin
      n_fail++;
      $display("FAIL b2b_hold: flush=%0b redirect=%h, expected %0b/%h", o_flush, o_redirect_pc, e.flush, e.redir);
    end
    i_pc = 32'hFFFF_FFFC;
    #1;
    n_tests++;
    if (o_pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_alloc: taken=%0b, expected 0", o_pred_taken);
    end
  endtask

  task automatic test_illegal();
    i_pc = 32'h140;
    for (int i = 0; i < 2; i++) begin
      resolve((i == 0) ? 3'b010 : 3'b011, 32'h140, 32'h700, 1'b1, 1'b1, 1'b0, 32'h0);
      #1;
      n_tests++;
      if (o_ex_taken !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_taken_%0d: got %0b, expected 0", i, o_ex_taken);
      end
      tick();
      n_tests++;
      if (o_flush !== e.flush || o_redirect_pc !== e.redir || o_pred_taken !== 1'b1 || o_pred_target !== 32'h600) begin
        n_fail++;
        $display("FAIL illegal_state_%0d: flush=%0b redirect=%h pred=%0b/%h, expected %0b/%h 1/00000600", i, o_flush, o_redirect_pc, o_pred_taken, o_pred_target, e.flush, e.redir);
      end
    end
  endtask

  task automatic test_mid_reset();
    resolve(3'b000, 32'h100, 32'h80, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    n_tests++;
    if (o_flush !== e.flush || o_redirect_pc !== e.redir) begin
      n_fail++;
      $display("FAIL mrst_pre: flush=%0b redirect=%h, expected %0b/%h", o_flush, o_redirect_pc, e.flush, e.redir);
    end
    i_rst_n = 1'b0;
    last_redir = '0;
    sb.delete();
    #1;
    n_tests++;
    if (o_flush !== 1'b0 || o_redirect_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL mrst_flush: flush=%0b redirect=%h, expected 0/0", o_flush, o_redirect_pc);
    end
    i_pc = 32'h140;
    #1;
    n_tests++;
    if (o_pred_taken !== 1'b0 || o_pred_target !== 32'h0) begin
      n_fail++;
      $display("FAIL mrst_miss: taken=%0b target=%h, expected 0/0", o_pred_taken, o_pred_target);
    end
    i_rst_n = 1'b1;
    i_pc = 32'h100;
    resolve(3'b000, 32'h100, 32'h80, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    n_tests++;
    if (o_flush !== e.flush || o_redirect_pc !== e.redir || o_pred_taken !== 1'b1 || o_pred_target !== 32'h80) begin
      n_fail++;
      $display("FAIL mrst_first_edge: flush=%0b redirect=%h pred=%0b/%h, expected %0b/%h 1/00000080", o_flush, o_redirect_pc, o_pred_taken, o_pred_target, e.flush, e.redir);
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_unsigned();
    test_alias();
    test_back_to_back();
    test_illegal();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter INDEX_W, default 4, SHALL set table depth to 2**INDEX_W entries, indexed by PC[INDEX_W+1:2].
REQ-002 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_pc  input  32  fetch-stage PC to predict.
REQ-005 o_pred_taken  output  1  prediction for i_pc, combinational from registered table.
REQ-006 o_pred_target  output  32  predicted target for i_pc; 0 when o_pred_taken=0.
REQ-007 i_ex_valid  input  1  execute-stage instruction valid.
REQ-008 i_ex_is_br  input  1  execute-stage instruction is a conditional branch.
REQ-009 i_ex_funct3  input  3  branch funct3.
REQ-010 i_ex_pc  input  32  PC of the execute-stage branch.
REQ-011 i_ex_target  input  32  computed branch target.
REQ-012 i_ex_pred_taken / i_ex_pred_target  input  1/32  prediction carried down the pipe with the branch.
REQ-013 i_br_less / i_br_equal  input  1/1  branch comparator flags for the execute-stage operands.
REQ-014 o_br_un  output  1  unsigned-compare select to the comparator, equal to i_ex_funct3[1].
REQ-015 o_ex_taken  output  1  resolved outcome, combinational.
REQ-016 o_flush  output  1  registered one-cycle mispredict pulse.
REQ-017 o_redirect_pc  output  32  registered correct next PC, valid while o_flush=1.

Function
REQ-018 Resolution SHALL be: 000 taken=equal; 001 taken=!equal; 100 or 110 taken=less; 101 or 111 taken=!less; 010 and 011 are illegal, taken=0, no update, no flush.
REQ-019 A branch is resolved only when i_ex_valid=1, i_ex_is_br=1 and funct3 is legal; otherwise o_ex_taken=0 and no state changes.
REQ-020 Entry fields SHALL be: valid, tag PC[31:INDEX_W+2], target[31:0], 2-bit counter (SNT=0, WNT=1, WT=2, ST=3).
REQ-021 Prediction is a hit when valid=1 and tag matches; o_pred_taken = hit AND counter[1]; o_pred_target = entry target.
REQ-022 A resolved branch that hits SHALL saturate the counter (+1 if taken, max 3; -1 if not taken, min 0) and, when taken, rewrite target.
REQ-023 A resolved taken branch that misses SHALL allocate the entry: valid=1, new tag, target=i_ex_target, counter=WT. A not-taken miss SHALL NOT allocate.
REQ-024 Mispredict = resolved AND (taken != i_ex_pred_taken OR (taken AND i_ex_pred_target != i_ex_target)).
REQ-025 On mispredict, o_flush SHALL be 1 in the next cycle only, with o_redirect_pc = taken ? i_ex_target : i_ex_pc+4, computed modulo 2**32 (0xFFFFFFFC+4 = 0x00000000).
REQ-026 Back-to-back mispredicts SHALL produce back-to-back flush pulses, each carrying its own redirect PC.
REQ-027 When i_pc and i_ex_pc share an index in the same cycle, prediction SHALL use the pre-update entry (write-then-visible next cycle).
REQ-028 o_redirect_pc SHALL hold its last value when o_flush=0.

Reset
REQ-029 Asserting i_rst_n=0 at any time, including mid-update, SHALL immediately clear all valid bits, set every counter to WNT, and drive o_flush=0 and o_redirect_pc=0.
REQ-030 With all entries invalid after reset, o_pred_taken=0 and o_pred_target=0.
REQ-031 The first rising edge after deassertion SHALL perform normal updates.

Structure
REQ-032 Shared package bpu_pkg SHALL hold the funct3 branch constants, the 2-bit counter enum, and default INDEX_W.
REQ-033 Sub-module br_resolve SHALL hold the combinational funct3/flag-to-taken decode and o_br_un.
REQ-034 Target and tag storage SHALL be flop arrays, with no memory macro.

Verification
REQ-035 Reset, then i_pc=0x100 -> o_pred_taken=0 and o_pred_target=0; o_flush stays 0.
REQ-036 BEQ at 0x100, target 0x80, equal=1, pred 0 -> next cycle o_flush=1 and o_redirect_pc=0x80; then i_pc=0x100 -> taken, target 0x80 (WT).
REQ-037 Same entry, not-taken twice (equal=0) -> counter WT->WNT->SNT; second resolve flushes with redirect 0x104; four taken resolves saturate at ST.
REQ-038 BLTU rs1=0x1, rs2=0xFFFFFFFF -> o_br_un=1, less=1, taken; BLT on the same operands -> o_br_un=0, less=0, not taken.
REQ-039 Aliasing: 0x100 allocated, then taken branch at 0x140 (same index, new tag) -> entry replaced; i_pc=0x100 -> miss. Simultaneous predict/update at one index -> old value seen.
REQ-040 Mid-run i_rst_n pulse during a flush cycle -> o_flush drops at once and all predictions miss; funct3=010 -> no flush and no table change.
